uart_rx_fsm: RTL and testbench

- Frame sequencer for the UART receiver. Sits between the rx_in line and the receive datapath: data sampler, deserializer, start/parity/stop checkers.
- Owns the edge and bit counters and issues one-cycle check and shift strobes at mid-bit.
- Collects checker verdicts and raises data_valid or an error flag per frame.
- Contains no data storage; the deserializer holds the byte.

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_edge_bit_counter.sv | 55 +++++
 rtl/uart_rx_fsm.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int MIN_PRESCALE = 8;
  localparam int CHK_OFFSET   = 2;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Edge counter (clock index within a bit, wrapping at the bit boundary) and
// data bit counter for the UART receive sequencer.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_edge_clr,
  input  logic                      i_edge_load,
  input  logic [PRESCALE_WIDTH-1:0] i_last_edge,
  input  logic                      i_bit_clr,
  input  logic                      i_bit_inc,
  output logic [PRESCALE_WIDTH-1:0] o_edge_cnt,
  output logic [3:0]                o_bit_cnt,
  output logic                      o_at_last
);

  localparam logic [PRESCALE_WIDTH-1:0] EDGE_ZERO = {PRESCALE_WIDTH{1'b0}};
  localparam logic [PRESCALE_WIDTH-1:0] EDGE_ONE  = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic [3:0]                r_bit_cnt;

  assign o_at_last  = (r_edge_cnt == i_last_edge);
  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;

  // Edge counter: load 1 on start detect (the detect cycle is edge 0).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_edge_cnt <= EDGE_ZERO;
    end else if (i_edge_clr) begin
      r_edge_cnt <= EDGE_ZERO;
    end else if (i_edge_load) begin
      r_edge_cnt <= EDGE_ONE;
    end else if (i_en) begin
      r_edge_cnt <= o_at_last ? EDGE_ZERO : (r_edge_cnt + EDGE_ONE);
    end
  end

  // Bit counter holds its value outside the data field.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt <= 4'd0;
    end else if (i_bit_clr) begin
      r_bit_cnt <= 4'd0;
    end else if (i_bit_inc) begin
      r_bit_cnt <= r_bit_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: tracks frame position, issues mid-bit check
// and shift strobes, and reports one data_valid or frame_err pulse per frame.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      par_en,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      dat_samp_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      deser_en,
  output logic                      data_valid,
  output logic                      frame_err,
  output logic                      par_err_flag
);

  localparam logic [PRESCALE_WIDTH-1:0] PS_MIN   = PRESCALE_WIDTH'(MIN_PRESCALE);
  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE   = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_WIDTH-1:0] CHK_OFFS = PRESCALE_WIDTH'(CHK_OFFSET);
  localparam logic [3:0]                LAST_BIT = 4'(DATA_WIDTH - 1);

  rx_state_t                 r_state;
  rx_state_t                 w_next_state;
  logic [PRESCALE_WIDTH-1:0] r_ps;
  logic                      r_par_en;
  logic                      r_par_err_flag;
  logic                      r_data_valid;
  logic                      r_frame_err;

  logic [PRESCALE_WIDTH-1:0] w_ps_eff;
  logic [PRESCALE_WIDTH-1:0] w_chk_edge;
  logic [PRESCALE_WIDTH-1:0] w_last_edge;
  logic                      w_at_chk;
  logic                      w_at_last;
  logic                      w_edge_clr;
  logic                      w_edge_load;
  logic                      w_bit_clr;
  logic                      w_bit_inc;
  logic                      w_start_det;
  logic                      w_par_sample;
  logic                      w_frame_done;
  logic                      w_frame_bad;

  assign w_ps_eff    = (prescale < PS_MIN) ? PS_MIN : prescale;
  assign w_chk_edge  = (r_ps >> 1) + CHK_OFFS;
  assign w_last_edge = r_ps - PS_ONE;
  assign w_at_chk    = (edge_cnt == w_chk_edge);
  assign w_frame_bad = stp_err | r_par_err_flag;

  assign data_valid   = r_data_valid;
  assign frame_err    = r_frame_err;
  assign par_err_flag = r_par_err_flag;

  uart_rx_edge_bit_counter #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_cnt (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_en       (dat_samp_en),
    .i_edge_clr (w_edge_clr),
    .i_edge_load(w_edge_load),
    .i_last_edge(w_last_edge),
    .i_bit_clr  (w_bit_clr),
    .i_bit_inc  (w_bit_inc),
    .o_edge_cnt (edge_cnt),
    .o_bit_cnt  (bit_cnt),
    .o_at_last  (w_at_last)
  );

  // Next-state, counter control and mid-bit strobes.
  always_comb begin
    w_next_state = r_state;
    w_edge_clr   = 1'b0;
    w_edge_load  = 1'b0;
    w_bit_clr    = 1'b0;
    w_bit_inc    = 1'b0;
    w_start_det  = 1'b0;
    w_par_sample = 1'b0;
    w_frame_done = 1'b0;
    dat_samp_en  = (r_state != ST_IDLE);
    strt_chk_en  = 1'b0;
    par_chk_en   = 1'b0;
    stp_chk_en   = 1'b0;
    deser_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rx_in) begin
          w_start_det  = 1'b1;
          w_edge_load  = 1'b1;
          w_next_state = ST_START;
        end else begin
          w_edge_clr   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_START: begin
        strt_chk_en = w_at_chk;
        if (w_at_chk && strt_glitch) begin
          w_edge_clr   = 1'b1;
          w_next_state = ST_IDLE;
        end else if (w_at_last) begin
          w_bit_clr    = 1'b1;
          w_next_state = ST_DATA;
        end else begin
          w_next_state = ST_START;
        end
      end
      ST_DATA: begin
        deser_en = w_at_chk;
        if (w_at_last && (bit_cnt == LAST_BIT)) begin
          w_next_state = r_par_en ? ST_PARITY : ST_STOP;
        end else if (w_at_last) begin
          w_bit_inc = 1'b1;
        end else begin
          w_next_state = ST_DATA;
        end
      end
      ST_PARITY: begin
        par_chk_en   = w_at_chk;
        w_par_sample = w_at_chk;
        if (w_at_last) begin
          w_next_state = ST_STOP;
        end else begin
          w_next_state = ST_PARITY;
        end
      end
      ST_STOP: begin
        stp_chk_en = w_at_chk;
        // Leave mid stop bit so a back-to-back start edge is not missed.
        if (w_at_chk) begin
          w_frame_done = 1'b1;
          w_edge_clr   = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_STOP;
        end
      end
      default: begin
        w_edge_clr   = 1'b1;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, per-frame configuration and verdict registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state        <= ST_IDLE;
      r_ps           <= PS_MIN;
      r_par_en       <= 1'b0;
      r_par_err_flag <= 1'b0;
      r_data_valid   <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_data_valid <= w_frame_done & ~w_frame_bad;
      r_frame_err  <= w_frame_done & w_frame_bad;
      if (w_start_det) begin
        r_ps           <= w_ps_eff;
        r_par_en       <= par_en;
        r_par_err_flag <= 1'b0;
      end else if (w_par_sample) begin
        r_par_err_flag <= par_err;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: directed and randomized frames checked
// cycle by cycle against expectations computed from frame position arithmetic.
module tb_uart_rx_fsm;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK;
  logic          RST;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en;
  logic          strt_glitch;
  logic          par_err;
  logic          stp_err;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          dat_samp_en;
  logic          strt_chk_en;
  logic          par_chk_en;
  logic          stp_chk_en;
  logic          deser_en;
  logic          data_valid;
  logic          frame_err;
  logic          par_err_flag;

  int n_pass  = 0;
  int n_total = 0;

  bit carry_dv   = 1'b0;
  bit carry_fe   = 1'b0;
  bit carry_flag = 1'b0;

  uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .deser_en    (deser_en),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .par_err_flag(par_err_flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic check_outputs(input int e_edge, input logic [4:0] e_strb, input bit e_dv,
                               input bit e_fe, input bit e_flag);
    chk("edge_cnt", 32'(edge_cnt), 32'(e_edge));
    chk("strobes{samp,strt,deser,par,stp}",
        32'({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en}), 32'(e_strb));
    chk("data_valid", 32'(data_valid), 32'(e_dv));
    chk("frame_err", 32'(frame_err), 32'(e_fe));
    chk("par_err_flag", 32'(par_err_flag), 32'(e_flag));
  endtask

  // Idle line for n cycles; the previous frame's verdict shows in the first one.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rx_in       = 1'b1;
      RST         = 1'b0;
      prescale    = PW'($urandom);
      par_en      = 1'($urandom);
      strt_glitch = 1'($urandom);
      par_err     = 1'($urandom);
      stp_err     = 1'($urandom);
      @(negedge CLK);
      check_outputs(0, 5'b00000, carry_dv, carry_fe, carry_flag);
      @(posedge CLK);
      #1;
      carry_dv = 1'b0;
      carry_fe = 1'b0;
    end
  endtask

  // One frame whose start edge is seen in the first cycle (relative cycle r=0).
  task automatic run_frame(input int ps_in, input bit pe, input bit glitch, input bit perr,
                           input bit serr, input bit brk, input int rst_at);
    int ps, chk_e, nbits, last, b, e, par_chk_cyc;
    bit hit_rst;
    logic [DW-1:0] data;
    logic [4:0] strb;
    bit e_dv, e_fe, e_flag;
    ps          = (ps_in < 8) ? 8 : ps_in;
    chk_e       = ps / 2 + 2;
    nbits       = 1 + DW + (pe ? 1 : 0);
    last        = glitch ? chk_e : ps * nbits + chk_e;
    par_chk_cyc = ps * (DW + 1) + chk_e;
    data        = DW'($urandom);
    hit_rst     = 1'b0;
    for (int r = 0; r <= last; r++) begin
      b = r / ps;
      e = r % ps;
      prescale = (r == 0) ? PW'(ps_in) : PW'($urandom);
      par_en   = (r == 0) ? pe : 1'($urandom);
      if (b == 0)                   rx_in = glitch ? (r >= 3) : 1'b0;
      else if (b <= DW)             rx_in = data[b-1];
      else if (pe && b == DW + 1)   rx_in = ^data;
      else                          rx_in = ~brk;
      strt_glitch = (b == 0 && e == chk_e) ? glitch : 1'($urandom);
      par_err     = (pe && b == DW + 1 && e == chk_e) ? perr : 1'($urandom);
      stp_err     = (b == nbits && e == chk_e) ? serr : 1'($urandom);
      RST         = (r == rst_at);
      @(negedge CLK);
      strb[4] = (r > 0);
      strb[3] = (b == 0 && e == chk_e);
      strb[2] = (b >= 1 && b <= DW && e == chk_e);
      strb[1] = (pe && b == DW + 1 && e == chk_e);
      strb[0] = (b == nbits && e == chk_e);
      e_dv    = (r == 0) ? carry_dv : 1'b0;
      e_fe    = (r == 0) ? carry_fe : 1'b0;
      if (r == 0)                          e_flag = carry_flag;
      else if (pe && r > par_chk_cyc)      e_flag = perr;
      else                                 e_flag = 1'b0;
      check_outputs(e, strb, e_dv, e_fe, e_flag);
      if (b >= 1 && b <= DW) chk("bit_cnt", 32'(bit_cnt), 32'(b - 1));
      @(posedge CLK);
      #1;
      if (r == rst_at) begin
        hit_rst = 1'b1;
        break;
      end
    end
    RST = 1'b0;
    if (hit_rst || glitch) begin
      carry_dv   = 1'b0;
      carry_fe   = 1'b0;
      carry_flag = 1'b0;
    end else begin
      carry_fe   = serr | (pe & perr);
      carry_dv   = ~carry_fe;
      carry_flag = pe & perr;
    end
    if (hit_rst) chk("bit_cnt after reset", 32'(bit_cnt), 32'd0);
  endtask

  initial begin
    int ps_r, gap;
    bit pe_r, gl_r, perr_r, serr_r, brk_r;
    RST         = 1'b1;
    rx_in       = 1'b1;
    prescale    = PW'(8);
    par_en      = 1'b0;
    strt_glitch = 1'b0;
    par_err     = 1'b0;
    stp_err     = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("bit_cnt at reset", 32'(bit_cnt), 32'd0);
    idle(3);

    // Clean frame, then back-to-back frame with prescale 4 (treated as 8).
    run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_frame(4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(4);

    // Start glitch aborts silently.
    run_frame(8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(5);

    // Parity error, flag persists in idle and clears on the next start.
    run_frame(8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    idle(3);
    run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(2);

    // Stop error without parity at PS=16.
    run_frame(16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    idle(3);

    // Break: line held low through stop, restarts immediately.
    run_frame(10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    run_frame(10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(2);

    // Reset in the middle of the data field, then a clean frame.
    run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40);
    idle(3);
    run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(2);

    for (int k = 0; k < 8; k++) begin
      ps_r   = int'($urandom_range(0, 63));
      pe_r   = 1'($urandom);
      gl_r   = ($urandom_range(0, 5) == 0);
      perr_r = 1'($urandom);
      serr_r = ($urandom_range(0, 2) == 0);
      brk_r  = serr_r & 1'($urandom);
      gap    = int'($urandom_range(0, 3));
      run_frame(ps_r, pe_r, gl_r, perr_r, serr_r, brk_r, -1);
      if (gap > 0) idle(gap);
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
